// File: rtl/cam_emu_pkg.sv
// Shared definitions for the camera emulator.
// Holds the FSM state encoding, the MODE encodings, the pattern colours and
// the default OV7670-style QCIF timing values.
package cam_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VSYNC   = 3'd1,
    ST_V_BACK  = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_V_FRONT = 3'd4
  } cam_state_t;

  localparam logic [1:0] MODE_SOLID    = 2'd0;
  localparam logic [1:0] MODE_BARS     = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;
  localparam logic [1:0] MODE_GRADIENT = 2'd3;

  // Bar colours, index 0 is the leftmost bar (packed: first listed = index 7).
  localparam logic [7:0][15:0] BAR_COLORS = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  localparam logic [15:0] CHECK_EVEN = 16'hF800;
  localparam logic [15:0] CHECK_ODD  = 16'hFFFF;

  localparam int DEF_H_ACTIVE    = 176;
  localparam int DEF_V_ACTIVE    = 144;
  localparam int DEF_H_BLANK     = 48;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_V_FRONT     = 10;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern generator.
// Ports:
//   x, y   : pixel coordinates within the active window
//   mode   : pattern select (solid, bars, checkerboard, gradient)
//   color  : RGB565 colour used by the solid pattern
//   pixel  : RGB565 result
module cam_pattern_gen
  import cam_emu_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [1:0]  mode,
  input  logic [15:0] color,
  output logic [15:0] pixel
);

  logic [10:0] bar_num;
  logic [2:0]  bar_idx;
  logic        unused_y_bits;

  // bar = x*8/H_ACTIVE; clamped so coordinates past the active width
  // cannot index outside the colour table.
  assign bar_num = 11'({x, 3'b000} / H_ACTIVE);
  assign bar_idx = (bar_num > 11'd7) ? 3'd7 : bar_num[2:0];

  // The low row bits only matter for finer patterns than these.
  assign unused_y_bits = ^y[2:0];

  always_comb begin
    pixel = color;
    case (mode)
      MODE_SOLID:    pixel = color;
      MODE_BARS:     pixel = BAR_COLORS[bar_idx];
      MODE_CHECKER:  pixel = (x[4] ^ y[4]) ? CHECK_ODD : CHECK_EVEN;
      MODE_GRADIENT: pixel = {x[7:3], 6'b000000, y[7:3]};
      default:       pixel = color;
    endcase
  end

endmodule

// File: rtl/camera_emulator.sv
// OV7670-style parallel camera bus transmitter producing test patterns.
// PCLK runs at CLK/2; HREF, VSYNC and DATA are registered and only change on
// the CLK edge where PCLK falls, so they are stable around every PCLK rise.
// Ports:
//   CLK, RESET_N : system clock, asynchronous active-low reset
//   ENABLE       : run frames back to back while high (sampled at frame edges)
//   MODE, COLOR  : pattern select and solid colour, latched at frame start
//   PCLK, HREF, VSYNC, DATA : camera bus towards the receiver
//   FRAME_DONE   : one-CLK pulse on the last byte of every frame
//   DBG_STATE    : current frame FSM state
module camera_emulator
  import cam_emu_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [1:0]  MODE,
  input  logic [15:0] COLOR,
  output logic        PCLK,
  output logic        HREF,
  output logic        VSYNC,
  output logic [7:0]  DATA,
  output logic        FRAME_DONE,
  output logic [2:0]  DBG_STATE
);

  localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
  localparam int MAX_LINES = max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT);
  localparam int BYTE_W    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LINE_W    = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(LINE_LEN - 1);
  localparam logic [BYTE_W-1:0] HREF_END  = BYTE_W'(2 * H_ACTIVE);
  localparam logic [LINE_W-1:0] FRONT_END = LINE_W'(V_FRONT - 1);

  cam_state_t        state, nxt_state;
  logic              phase;
  logic              fall;
  logic [BYTE_W-1:0] byte_cnt, nxt_byte;
  logic [LINE_W-1:0] line_cnt, nxt_line, line_last;
  logic [1:0]        mode_q;
  logic [15:0]       color_q;
  logic [15:0]       pixel;
  logic              nxt_href, nxt_vsync, nxt_done;
  logic [7:0]        nxt_data;

  // phase is PCLK; when it is 1 the coming edge is the PCLK falling edge,
  // the only edge on which the bus and the frame position move.
  assign fall      = phase;
  assign PCLK      = phase;
  assign DBG_STATE = state;

  always_comb begin
    line_last = '0;
    case (state)
      ST_VSYNC:   line_last = LINE_W'(VSYNC_LINES - 1);
      ST_V_BACK:  line_last = LINE_W'(V_BACK - 1);
      ST_ACTIVE:  line_last = LINE_W'(V_ACTIVE - 1);
      ST_V_FRONT: line_last = FRONT_END;
      default:    line_last = '0;
    endcase
  end

  // Next frame position. IDLE keeps both counters at zero, so entering
  // VSYNC starts at byte 0 of line 0.
  always_comb begin
    nxt_state = state;
    nxt_byte  = byte_cnt;
    nxt_line  = line_cnt;
    if (fall) begin
      if (state == ST_IDLE) begin
        if (ENABLE) nxt_state = ST_VSYNC;
      end else if (byte_cnt == BYTE_LAST) begin
        nxt_byte = '0;
        if (line_cnt == line_last) begin
          nxt_line = '0;
          case (state)
            ST_VSYNC:   nxt_state = ST_V_BACK;
            ST_V_BACK:  nxt_state = ST_ACTIVE;
            ST_ACTIVE:  nxt_state = ST_V_FRONT;
            ST_V_FRONT: nxt_state = ENABLE ? ST_VSYNC : ST_IDLE;
            default:    nxt_state = ST_IDLE;
          endcase
        end else begin
          nxt_line = line_cnt + 1'b1;
        end
      end else begin
        nxt_byte = byte_cnt + 1'b1;
      end
    end
  end

  // Outputs are derived from the position being entered, so the registered
  // bus lines up with the counters after the edge.
  cam_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .x     (8'(nxt_byte >> 1)),
    .y     (8'(nxt_line)),
    .mode  (mode_q),
    .color (color_q),
    .pixel (pixel)
  );

  always_comb begin
    nxt_href  = (nxt_state == ST_ACTIVE) && (nxt_byte < HREF_END);
    nxt_vsync = (nxt_state == ST_VSYNC);
    nxt_done  = (nxt_state == ST_V_FRONT) && (nxt_line == FRONT_END) &&
                (nxt_byte == BYTE_LAST);
    nxt_data  = 8'h00;
    if (nxt_href) nxt_data = nxt_byte[0] ? pixel[7:0] : pixel[15:8];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase      <= 1'b0;
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      line_cnt   <= '0;
      mode_q     <= MODE_SOLID;
      color_q    <= '0;
      HREF       <= 1'b0;
      VSYNC      <= 1'b0;
      DATA       <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      phase      <= ~phase;
      FRAME_DONE <= 1'b0;
      if (fall) begin
        state      <= nxt_state;
        byte_cnt   <= nxt_byte;
        line_cnt   <= nxt_line;
        HREF       <= nxt_href;
        VSYNC      <= nxt_vsync;
        DATA       <= nxt_data;
        FRAME_DONE <= nxt_done;
        // Pattern inputs are frozen for the whole frame from VSYNC entry.
        if (nxt_state == ST_VSYNC && state != ST_VSYNC) begin
          mode_q  <= MODE;
          color_q <= COLOR;
        end
      end
    end
  end

endmodule
